led_pattern_counter: RTL
========================

# led_pattern_counter

Parametrised LED pattern generator for the DE0-Nano LED bank. It divides the 50 MHz board clock to a slow advance tick and drives `WIDTH` LEDs with one of four patterns: binary up, binary down, Gray-code up, or a single bouncing LED. It adds enable, single-step and parallel load, and it reports tick and wrap events. It sits directly between the board clock and the LED pins, or feeds any status display that needs a visible counter.

## Interface
- `WIDTH`, 8: LED count, 2..32.
- `CLK_HZ`, 50_000_000: input clock frequency.
- `TICK_HZ`, 2: advance rate. `DIV = CLK_HZ/TICK_HZ` must be ≥ 2 (elaboration error otherwise).
- `clk`  in  1  board clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `en`  in  1  free-run enable.
- `step`  in  1  single-step request, used only when `en`=0.
- `mode`  in  2  0 = binary up, 1 = binary down, 2 = Gray up, 3 = ping-pong.
- `load`  in  1  parallel load strobe.
- `load_val`  in  WIDTH  load value.
- `led`  out  WIDTH  pattern output.
- `tick`  out  1  one-cycle pulse per advance.
- `wrap`  out  1  one-cycle pulse when the pattern completes a period.

## Operation
- **State registers:**
  - `presc`: clog2(DIV) bits.
  - `cnt`: WIDTH bits.
  - `pos`: clog2(WIDTH) bits.
  - `dir`: 0 = up.
  - `mode_q`: 2 bits.
  - `tick`, `wrap`: registered pulses.
- **Reset:** all state registers are 0, which gives `led`=0, `tick`=0, `wrap`=0.
- **`led` decode:** `led` is a pure decode of registered state. There is no combinational path from any input to any output.
  - `mode_q` 0/1: `led = cnt`.
  - `mode_q` 2: `led = cnt ^ (cnt >> 1)`.
  - `mode_q` 3: `led = 1 << pos`.
- **Advance condition:** `adv = (en && presc == DIV-1) || (!en && step)`.
  - With `en`=1, `presc` counts 0..DIV-1 and wraps to 0.
  - With `en`=0, `presc` holds its value.
- **Advance action by `mode_q`:**
  - 0: `cnt+1` mod 2^WIDTH.
  - 1: `cnt-1` mod 2^WIDTH.
  - 2: `cnt+1`.
  - 3: if `dir`=0, `pos+1`, and `dir` becomes 1 when `pos` reaches WIDTH-1. If `dir`=1, `pos-1`, and `dir` becomes 0 when `pos` reaches 0. The period is 2·WIDTH-2 advances.
- **`wrap` conditions** (evaluated on the advance):
  - Mode 0/2: `cnt` goes all-ones → 0.
  - Mode 1: `cnt` goes 0 → all-ones.
  - Mode 3: `pos` goes 1 → 0.
- **Priority per cycle**, highest first:
  1. `rst`.
  2. Mode change (`mode != mode_q`): `mode_q <= mode`, `cnt`=0, `pos`=0, `dir`=0, `presc`=0, no advance, no tick.
  3. `load`: `cnt <= load_val`, `presc`=0, no advance, no tick. In mode 3, `load` is ignored entirely and the advance proceeds normally.
  4. Advance.
- **`step` while `en`=1:** ignored.
- **`step` held high with `en`=0:** one advance per cycle. A caller needing a single advance must supply a one-cycle pulse.

## Timing
- **Advance latency:** an advance takes effect at the clock edge where `adv` is true. From the next cycle on, `led` shows the new value, and `tick` (and `wrap` when applicable) is high for exactly that one cycle.
- **Free-run period:** exactly DIV cycles between `tick` pulses. With the defaults this is 25,000,000 cycles, i.e. 0.5 s.
- **First tick after reset release with `en`=1:** `tick` rises DIV cycles after the first cycle with `rst`=0. Entering free-run from `en`=0 gives the same timing when `presc` is 0.
- **Mode change:** takes one cycle. The new pattern's initial value appears on `led` the cycle after the edge that samples the new `mode`. In mode 3 that value is `led`=1.
- **Load:** `load_val` appears on `led` one cycle after the `load` edge. The next free-run tick follows DIV cycles later.
- **`rst` mid-count:** aborts immediately. A `tick` or `wrap` pending that same edge is suppressed.
- **`en` deassert:** freezes `presc` and `led` with no partial tick. Reasserting `en` resumes from the held `presc` value.

## Test plan
Bench uses WIDTH=8, CLK_HZ=10, TICK_HZ=2, giving DIV=5.
- **Free-run up:** reset, mode=0, en=1 for 30 cycles → `led` = 0,1,…,6 advancing every 5 cycles; `tick` high 1 cycle each time; first tick 5 cycles after reset release.
- **Wrap, both directions:**
  - mode=0, load 0xFE, run 2 ticks → `led` 0xFF, then 0x00 with `wrap`=1.
  - mode=1 from 0 → `led` 0xFF with `wrap`=1.
- **Gray:** mode=2, 8 ticks → `led` = 00,01,03,02,06,07,05,04; exactly one bit changes per tick.
- **Ping-pong:** mode=3, 16 ticks → `led` 01,02,…,80,40,…,01,02; `wrap` only on the tick arriving at 01 (tick 14).
- **Step/priority:**
  - en=0, three 1-cycle `step` pulses → 3 advances; `presc` frozen.
  - `load` and `step` in the same cycle → load wins, no tick.
  - `mode` change and `load` in the same cycle → mode change wins, `led`=0.
- **Reset mid-operation:** assert `rst` on the edge where `presc`=4 → no tick; `led`=0 the next cycle; counting restarts with the full 5-cycle period.

Source files
------------

// File: rtl/led_pattern_counter.sv
// led_pattern_counter: divides the board clock to a slow advance tick and
// drives a WIDTH-wide LED bank with binary up/down, Gray up or a bouncing
// single LED. Supports free-run enable, single-step and parallel load, and
// reports one-cycle tick and wrap pulses. All outputs decode registered state.
module led_pattern_counter #(
  parameter int WIDTH   = 8,
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] led,
  output logic             tick,
  output logic             wrap
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  // Guarded so a bad DIV reports the intended error rather than a width error.
  localparam int PW  = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int QW  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);
  localparam logic [QW-1:0] POS_MAX   = QW'(WIDTH - 1);

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_GRAY = 2'd2;
  localparam logic [1:0] MODE_PING = 2'd3;

  if (DIV < 2) begin : g_div_check
    $error("led_pattern_counter: CLK_HZ/TICK_HZ must be at least 2");
  end

  if ((WIDTH < 2) || (WIDTH > 32)) begin : g_width_check
    $error("led_pattern_counter: WIDTH must be in 2..32");
  end

  logic [PW-1:0]    presc_q, presc_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [QW-1:0]    pos_q, pos_d;
  logic             dir_q, dir_d;
  logic [1:0]       mode_q, mode_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;

  logic             mode_chg_s;
  logic             load_s;
  logic             presc_end_s;
  logic             adv_s;
  logic [WIDTH-1:0] led_s;

  // Load is meaningless for the bouncing LED, so it is dropped in that mode.
  assign mode_chg_s  = (mode != mode_q);
  assign load_s      = load && (mode_q != MODE_PING);
  assign presc_end_s = (presc_q == PRESC_MAX);
  assign adv_s       = (en && presc_end_s) || (!en && step);

  // Next-state logic: reset-free priority of mode change, load, then advance.
  always_comb begin
    presc_d = presc_q;
    cnt_d   = cnt_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    if (mode_chg_s) begin
      mode_d  = mode;
      cnt_d   = {WIDTH{1'b0}};
      pos_d   = {QW{1'b0}};
      dir_d   = 1'b0;
      presc_d = {PW{1'b0}};
    end else if (load_s) begin
      cnt_d   = load_val;
      presc_d = {PW{1'b0}};
    end else begin
      if (en) begin
        presc_d = presc_end_s ? {PW{1'b0}} : (presc_q + {{(PW-1){1'b0}}, 1'b1});
      end else begin
        presc_d = presc_q;
      end
      if (adv_s) begin
        tick_d = 1'b1;
        case (mode_q)
          MODE_UP, MODE_GRAY: begin
            cnt_d  = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
            wrap_d = &cnt_q;
          end
          MODE_DOWN: begin
            cnt_d  = cnt_q - {{(WIDTH-1){1'b0}}, 1'b1};
            wrap_d = ~|cnt_q;
          end
          MODE_PING: begin
            if (!dir_q) begin
              pos_d = pos_q + {{(QW-1){1'b0}}, 1'b1};
              dir_d = ((pos_q + {{(QW-1){1'b0}}, 1'b1}) == POS_MAX);
            end else begin
              pos_d  = pos_q - {{(QW-1){1'b0}}, 1'b1};
              dir_d  = (pos_q != {{(QW-1){1'b0}}, 1'b1});
              wrap_d = (pos_q == {{(QW-1){1'b0}}, 1'b1});
            end
          end
          default: begin
            cnt_d = cnt_q;
          end
        endcase
      end else begin
        tick_d = 1'b0;
      end
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= {PW{1'b0}};
      cnt_q   <= {WIDTH{1'b0}};
      pos_q   <= {QW{1'b0}};
      dir_q   <= 1'b0;
      mode_q  <= 2'd0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      tick_q  <= tick_d;
      wrap_q  <= wrap_d;
    end
  end

  // LED decode from registered mode and counter/position only.
  always_comb begin
    led_s = {WIDTH{1'b0}};
    case (mode_q)
      MODE_UP, MODE_DOWN: led_s = cnt_q;
      MODE_GRAY:          led_s = cnt_q ^ (cnt_q >> 1);
      MODE_PING:          led_s = {{(WIDTH-1){1'b0}}, 1'b1} << pos_q;
      default:            led_s = {WIDTH{1'b0}};
    endcase
  end

  assign led  = led_s;
  assign tick = tick_q;
  assign wrap = wrap_q;

endmodule
